// File: rtl/threewire_slave.sv
// 3-wire serial register slave: R/W bit, address and data frames from an
// asynchronous master, turned into single-cycle register read/write strobes.
module threewire_slave #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_tw_clock,
  input  logic                 in_tw_cs,
  inout  wire                  io_tw_data,
  output logic [ADDR_BITS-1:0] out_reg_addr,
  output logic [DATA_BITS-1:0] out_reg_wr_data,
  output logic                 out_reg_wr_en,
  output logic                 out_reg_rd_en,
  input  logic [DATA_BITS-1:0] in_reg_rd_data,
  output logic                 out_busy
);

  localparam int MAX_BITS = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    ADDR     = 3'd2,
    RD_FETCH = 3'd3,
    RD_DATA  = 3'd4,
    WR_DATA  = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t state, next_state;

  logic clk_s1, clk_s2, clk_d;
  logic cs_s1, cs_s2, cs_d;
  logic dat_s1, dat_s2;
  logic live, armed;
  logic tw_rise, tw_fall, cs_fall;
  logic rw, fetch_ph, started;
  logic [CNT_W-1:0]     cnt;
  logic [ADDR_BITS-1:0] addr_sh;
  logic [DATA_BITS-1:0] sh;
  logic addr_last, data_last, tw_oe;

  // Synchronizers and edge history. "armed" blocks the false cs edge seen when
  // the synchronizer leaves reset while the master is still holding cs low.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      clk_s1 <= 1'b0; clk_s2 <= 1'b0; clk_d <= 1'b0;
      cs_s1  <= 1'b1; cs_s2  <= 1'b1; cs_d  <= 1'b1;
      dat_s1 <= 1'b0; dat_s2 <= 1'b0;
      live   <= 1'b0; armed  <= 1'b0;
    end else begin
      clk_s1 <= in_tw_clock; clk_s2 <= clk_s1; clk_d <= clk_s2;
      cs_s1  <= in_tw_cs;    cs_s2  <= cs_s1;  cs_d  <= cs_s2;
      dat_s1 <= io_tw_data;  dat_s2 <= dat_s1;
      live   <= 1'b1;
      armed  <= armed | (live & cs_s1 & cs_s2);
    end
  end

  assign tw_rise   = clk_s2 & ~clk_d;
  assign tw_fall   = ~clk_s2 & clk_d;
  assign cs_fall   = ~cs_s2 & cs_d & armed;
  assign addr_last = (cnt == CNT_W'(ADDR_BITS - 1));
  assign data_last = (cnt == CNT_W'(DATA_BITS - 1));

  // State register
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a deasserted cs aborts any unfinished frame
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cs_fall) next_state = CMD;
        else         next_state = IDLE;
      end
      CMD: begin
        if (cs_s2)        next_state = IDLE;
        else if (tw_rise) next_state = ADDR;
        else              next_state = CMD;
      end
      ADDR: begin
        if (cs_s2)                     next_state = IDLE;
        else if (tw_rise && addr_last) next_state = rw ? WR_DATA : RD_FETCH;
        else                           next_state = ADDR;
      end
      RD_FETCH: begin
        if (cs_s2)         next_state = IDLE;
        else if (fetch_ph) next_state = RD_DATA;
        else               next_state = RD_FETCH;
      end
      RD_DATA: begin
        if (cs_s2)                                next_state = IDLE;
        else if (tw_rise && started && data_last) next_state = DONE;
        else                                      next_state = RD_DATA;
      end
      WR_DATA: begin
        if (cs_s2)                     next_state = IDLE;
        else if (tw_rise && data_last) next_state = DONE;
        else                           next_state = WR_DATA;
      end
      DONE: begin
        if (cs_s2) next_state = IDLE;
        else       next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: shifting, capture registers and strobes
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rw              <= 1'b0;
      fetch_ph        <= 1'b0;
      started         <= 1'b0;
      cnt             <= '0;
      addr_sh         <= '0;
      sh              <= '0;
      out_reg_addr    <= '0;
      out_reg_wr_data <= '0;
      out_reg_wr_en   <= 1'b0;
      out_reg_rd_en   <= 1'b0;
      out_busy        <= 1'b0;
    end else begin
      out_reg_wr_en <= 1'b0;
      out_reg_rd_en <= 1'b0;
      out_busy      <= (next_state != IDLE);
      case (state)
        IDLE: begin
          cnt      <= '0;
          fetch_ph <= 1'b0;
          started  <= 1'b0;
        end
        CMD: begin
          if (tw_rise) rw <= dat_s2;
        end
        ADDR: begin
          if (!cs_s2 && tw_rise) begin
            addr_sh <= {addr_sh[ADDR_BITS-2:0], dat_s2};
            if (addr_last) begin
              out_reg_addr  <= {addr_sh[ADDR_BITS-2:0], dat_s2};
              out_reg_rd_en <= ~rw;
              cnt           <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        RD_FETCH: begin
          // Read data arrives one cycle after the strobe cycle.
          if (!cs_s2) begin
            fetch_ph <= 1'b1;
            if (fetch_ph) sh <= in_reg_rd_data;
          end
        end
        RD_DATA: begin
          if (!cs_s2 && tw_fall) begin
            if (!started) begin
              started <= 1'b1;
            end else begin
              sh  <= {sh[DATA_BITS-2:0], 1'b0};
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        WR_DATA: begin
          if (!cs_s2 && tw_rise) begin
            sh <= {sh[DATA_BITS-2:0], dat_s2};
            if (data_last) begin
              out_reg_wr_data <= {sh[DATA_BITS-2:0], dat_s2};
              out_reg_wr_en   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign tw_oe      = (state == RD_DATA) && !cs_s2;
  assign io_tw_data = tw_oe ? sh[DATA_BITS-1] : 1'bz;

endmodule

// File: tb/tb_threewire_slave.sv
// Directed bench for threewire_slave: acts as the 3-wire master and a simple
// registered register file, checking strobes, captured values and read data.
module tb_threewire_slave;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst, tw_clk, tw_cs, mdrive, mval;
  wire  tw_data;
  logic [8:0]  reg_addr;
  logic [15:0] wr_data, rd_data, mem_val, rv;
  logic wr_en, rd_en, busy;

  int checks = 0, errors = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, oe_hits = 0;
  int w0, r0, o0;
  logic [8:0]  last_wr_addr = 9'h000, last_rd_addr = 9'h000;
  logic [15:0] last_wr_data = 16'h0000;

  assign tw_data = mdrive ? mval : 1'bz;

  always #5 clk = ~clk;

  threewire_slave #(.ADDR_BITS(9), .DATA_BITS(16)) dut (
    .in_clk(clk), .in_rst(rst), .in_tw_clock(tw_clk), .in_tw_cs(tw_cs),
    .io_tw_data(tw_data), .out_reg_addr(reg_addr), .out_reg_wr_data(wr_data),
    .out_reg_wr_en(wr_en), .out_reg_rd_en(rd_en), .in_reg_rd_data(rd_data),
    .out_busy(busy)
  );

  // Register file: read data valid one cycle after the read strobe
  always @(posedge clk) if (rd_en) rd_data <= mem_val;

  always @(negedge clk) begin
    if (wr_en) begin wr_cnt++; last_wr_addr = reg_addr; last_wr_data = wr_data; end
    if (rd_en) begin rd_cnt++; last_rd_addr = reg_addr; end
    if (wr_en && rd_en) both_cnt++;
    if (dut.tw_oe) oe_hits++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tw_bit(input logic drive, input logic v, output logic sampled);
    mdrive = drive;
    mval   = v;
    repeat (H) @(negedge clk);
    tw_clk  = 1'b1;
    sampled = tw_data;
    repeat (H) @(negedge clk);
    tw_clk = 1'b0;
  endtask

  // One master frame; ndata data clocks, optional reset after rst_at data bits.
  task automatic frame(input logic rw, input logic [8:0] addr, input logic [15:0] data,
                       input int ndata, input int rst_at, output logic [15:0] rdv);
    logic [31:0] dw;
    logic s;
    dw  = {data, 16'h3C3C};
    rdv = 16'h0000;
    @(negedge clk);
    tw_cs = 1'b0;
    tw_bit(1'b1, rw, s);
    for (int i = 0; i < 9; i++) tw_bit(1'b1, addr[8-i], s);
    for (int i = 0; i < ndata; i++) begin
      if (rw) begin
        tw_bit(1'b1, dw[31-i], s);
      end else begin
        tw_bit(1'b0, 1'b0, s);
        if (i < 16) rdv[15-i] = s;
      end
      if (i == rst_at - 1) begin
        check("oe_before_reset", 32'(dut.tw_oe), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_mid_oe", 32'(dut.tw_oe), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_addr", 32'(reg_addr), 32'h0);
        check("rst_mid_wr_data", 32'(wr_data), 32'h0);
        check("rst_mid_strobes", 32'({wr_en, rd_en}), 32'd0);
      end
    end
    mdrive = 1'b0;
    repeat (H) @(negedge clk);
    tw_cs = 1'b1;
  endtask

  initial begin
    rst = 1'b1; tw_clk = 1'b0; tw_cs = 1'b1; mdrive = 1'b0; mval = 1'b0;
    mem_val = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_rd_en", 32'(rd_en), 32'd0);
    check("reset_addr", 32'(reg_addr), 32'h0);
    check("reset_wr_data", 32'(wr_data), 32'h0);
    check("reset_oe", 32'(dut.tw_oe), 32'd0);

    // Write 0x0A5 <- 0xBEEF
    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_hits;
    frame(1'b1, 9'h0A5, 16'hBEEF, 16, -1, rv);
    repeat (8) @(negedge clk);
    check("wr1_count", 32'(wr_cnt - w0), 32'd1);
    check("wr1_addr", 32'(last_wr_addr), 32'h0A5);
    check("wr1_data", 32'(last_wr_data), 32'hBEEF);
    check("wr1_no_rd", 32'(rd_cnt - r0), 32'd0);
    check("wr1_no_oe", 32'(oe_hits - o0), 32'd0);
    check("wr1_busy_end", 32'(busy), 32'd0);

    // Read 0x1FF -> 0x1234
    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_hits;
    mem_val = 16'h1234;
    frame(1'b0, 9'h1FF, 16'h0000, 16, -1, rv);
    repeat (8) @(negedge clk);
    check("rd1_count", 32'(rd_cnt - r0), 32'd1);
    check("rd1_addr", 32'(last_rd_addr), 32'h1FF);
    check("rd1_data", 32'(rv), 32'h1234);
    check("rd1_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("rd1_oe_used", 32'(oe_hits > o0), 32'd1);
    check("rd1_wr_data_held", 32'(wr_data), 32'hBEEF);
    check("rd1_oe_released", 32'(dut.tw_oe), 32'd0);

    // Truncated write: 8 of 16 data bits
    w0 = wr_cnt;
    frame(1'b1, 9'h055, 16'hCAFE, 8, -1, rv);
    check("trunc_busy_before", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check("trunc_busy_3cyc", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("trunc_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("trunc_wr_data_held", 32'(wr_data), 32'hBEEF);

    // 30 data clocks in a write frame
    w0 = wr_cnt;
    frame(1'b1, 9'h133, 16'hA5C3, 30, -1, rv);
    repeat (8) @(negedge clk);
    check("extra_count", 32'(wr_cnt - w0), 32'd1);
    check("extra_addr", 32'(last_wr_addr), 32'h133);
    check("extra_data", 32'(last_wr_data), 32'hA5C3);

    // Reset during read data after 5 bits, then a normal write
    w0 = wr_cnt; r0 = rd_cnt;
    mem_val = 16'h0FF0;
    frame(1'b0, 9'h0C3, 16'h0000, 16, 5, rv);
    repeat (8) @(negedge clk);
    check("rstrd_rd_count", 32'(rd_cnt - r0), 32'd1);
    check("rstrd_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("rstrd_busy", 32'(busy), 32'd0);
    w0 = wr_cnt;
    frame(1'b1, 9'h155, 16'h0F0F, 16, -1, rv);
    repeat (8) @(negedge clk);
    check("post_rst_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("post_rst_wr_addr", 32'(last_wr_addr), 32'h155);
    check("post_rst_wr_data", 32'(last_wr_data), 32'h0F0F);

    // Back-to-back write then read of 0x002
    w0 = wr_cnt; r0 = rd_cnt;
    frame(1'b1, 9'h002, 16'h5555, 16, -1, rv);
    repeat (4 * H) @(negedge clk);
    check("b2b_wr_first", 32'(wr_cnt - w0), 32'd1);
    check("b2b_rd_not_yet", 32'(rd_cnt - r0), 32'd0);
    mem_val = 16'h5555;
    frame(1'b0, 9'h002, 16'h0000, 16, -1, rv);
    repeat (8) @(negedge clk);
    check("b2b_wr_count", 32'(wr_cnt - w0), 32'd1);
    check("b2b_rd_count", 32'(rd_cnt - r0), 32'd1);
    check("b2b_wr_addr", 32'(last_wr_addr), 32'h002);
    check("b2b_rd_addr", 32'(last_rd_addr), 32'h002);
    check("b2b_rd_data", 32'(rv), 32'h5555);
    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/threewire_slave.md
THREEWIRE_SLAVE -- requirements
Module: threewire_slave

Interface
REQ-001 Parameter ADDR_BITS, default 9: width of the frame address field and of out_reg_addr.
REQ-002 Parameter DATA_BITS, default 16: width of the frame data field and of the register data ports.
REQ-003 in_clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 in_rst  input  1  reset, synchronous and active-high.
REQ-005 in_tw_clock  input  1  3-wire serial clock from the master, asynchronous to in_clk, idles low.
REQ-006 in_tw_cs  input  1  frame select from the master, active-low, asynchronous.
REQ-007 io_tw_data  inout  1  serial data; driven by this block only during read data phase, else high-Z.
REQ-008 out_reg_addr  output  ADDR_BITS  captured frame address.
REQ-009 out_reg_wr_data  output  DATA_BITS  captured write data.
REQ-010 out_reg_wr_en  output  1  one-cycle register write strobe.
REQ-011 out_reg_rd_en  output  1  one-cycle register read strobe.
REQ-012 in_reg_rd_data  input  DATA_BITS  register read data, valid exactly 1 in_clk after out_reg_rd_en.
REQ-013 out_busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-014 in_tw_clock, in_tw_cs and io_tw_data input SHALL each pass through a 2-flop synchronizer; edge detection uses the synchronized values only.
REQ-015 Frame: cs falls; bit 0 = R/W (1 = write, 0 = read); then ADDR_BITS address bits MSB first; then DATA_BITS data bits MSB first; cs rises.
REQ-016 Master-driven bits SHALL be sampled on a detected rising edge of the synchronized tw_clock.
REQ-017 Slave-driven read bits SHALL change only on a detected falling edge of the synchronized tw_clock.
REQ-018 Supported tw_clock high and low times: at least 4 in_clk cycles each; slower is unbounded.
REQ-019 States: IDLE, CMD, ADDR, RD_FETCH, RD_DATA, WR_DATA, DONE.
REQ-020 IDLE -> CMD on synchronized cs falling; CMD -> ADDR after the R/W bit is sampled.
REQ-021 ADDR -> RD_FETCH (read) or WR_DATA (write) after the last address bit is sampled; a bit counter tracks position.
REQ-022 RD_FETCH: out_reg_rd_en high exactly 1 cycle; in_reg_rd_data loaded into the shift register on the following cycle; then -> RD_DATA.
REQ-023 RD_DATA: io_tw_data driven with the MSB from the first falling edge after the fetch completes; one bit shifted per falling edge; -> DONE after the LSB has been driven and the next rising edge is seen.
REQ-024 WR_DATA: after the DATA_BITS-th bit is sampled, out_reg_wr_en SHALL pulse 1 cycle on the next in_clk, with out_reg_addr and out_reg_wr_data stable; -> DONE.
REQ-025 DONE: further tw_clock edges ignored, no further strobes; -> IDLE on synchronized cs rising.
REQ-026 cs rising in any state other than IDLE/DONE (truncated frame): -> IDLE next cycle, no wr_en, io_tw_data released in the same cycle.
REQ-027 io_tw_data output enable SHALL be high only in RD_DATA with synchronized cs low.
REQ-028 out_reg_addr and out_reg_wr_data SHALL hold their last captured values between frames.
REQ-029 At most one out_reg_rd_en or out_reg_wr_en pulse per frame; never both.

Reset
REQ-030 in_rst high on a rising in_clk edge SHALL force: state IDLE, out_reg_wr_en 0, out_reg_rd_en 0, out_busy 0, io_tw_data high-Z, out_reg_addr 0, out_reg_wr_data 0, counters and shift register 0, synchronizers cleared to tw_clock 0, cs 1.
REQ-031 Reset mid-frame SHALL abort with no strobe; after release the block waits for a fresh cs falling edge, ignoring the remainder of the interrupted frame.

Verification
REQ-032 Write: cs low, bits 1, addr 0x0A5, data 0xBEEF, half-period 4 cycles -> exactly one wr_en pulse with addr 0x0A5, wr_data 0xBEEF; io_tw_data high-Z throughout.
REQ-033 Read: bits 0, addr 0x1FF, in_reg_rd_data 0x1234 one cycle after rd_en -> one rd_en pulse, addr 0x1FF; master samples 0x1234 MSB first on its rising edges.
REQ-034 Truncated write: cs rises after 8 of 16 data bits -> no wr_en, state IDLE, out_busy 0 within 3 cycles of cs rising (synchronizer latency).
REQ-035 Extra clocks: 30 tw_clock pulses in a write frame -> one wr_en only, with the first 16 data bits; excess ignored.
REQ-036 Reset during RD_DATA after 5 bits -> io_tw_data high-Z next cycle, all outputs at reset values; next full write frame completes normally.
REQ-037 Back-to-back: write 0x002/0x5555 then read 0x002 with cs high 2 tw_clock periods between -> one wr_en then one rd_en, addresses correct.
